// File: rtl/alu_mdu.sv
// Execute-stage ALU with iterative RV32M multiply/divide behind a valid/ready handshake.
// Base ops take 1 cycle; mul/div run one bit per cycle and stall through in_ready.
//
// state | meaning
// IDLE  | ready for a request
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result held until out_ready

module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic             kill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Z,
    output logic             NEG
);

    localparam int SH_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] UNK_VAL  = {(WIDTH/2){2'b01}};
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        mode_q, mode_d;
    logic              fix_q, fix_d;
    logic              rneg_q, rneg_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  opb_q, opb_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              z_q, z_d;
    logic              n_q, n_d;

    logic              load;
    logic [WIDTH-1:0]  res_nx;
    logic [WIDTH-1:0]  base_res;
    logic [SH_W-1:0]   shamt;
    logic              a_s, b_s, sgn;

    logic [WIDTH:0]    mul_sum;
    logic [2*WIDTH-1:0] mul_prod, mul_fix;
    logic [WIDTH-1:0]  mul_res;
    logic [WIDTH:0]    div_shift, div_trial;
    logic              div_ok;
    logic [WIDTH-1:0]  div_rem, div_quo, div_res;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic en);
        return (en && v[WIDTH-1]) ? -v : v;
    endfunction

    assign shamt = b_in[SH_W-1:0];

    always_comb begin
        base_res = UNK_VAL;
        case (op)
            5'b00000: base_res = a_in + b_in;
            5'b00001: base_res = a_in - b_in;
            5'b00010: base_res = a_in & b_in;
            5'b00011: base_res = a_in ^ b_in;
            5'b00101: base_res = {{(WIDTH-1){1'b0}}, $signed(a_in) < $signed(b_in)};
            5'b00110: base_res = a_in | b_in;
            5'b01000: base_res = {{(WIDTH-1){1'b0}}, a_in < b_in};
            5'b01001: base_res = a_in << shamt;
            5'b01010: base_res = a_in >> shamt;
            5'b01011: base_res = $signed(a_in) >>> shamt;
            default:  base_res = UNK_VAL;
        endcase
    end

    // hi_q/lo_q hold the running product in MUL, remainder/quotient in DIV
    always_comb begin
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
        mul_prod = {mul_sum, lo_q[WIDTH-1:1]};
        mul_fix  = fix_q ? -mul_prod : mul_prod;
        mul_res  = (mode_q == 2'b00) ? mul_fix[WIDTH-1:0] : mul_fix[2*WIDTH-1:WIDTH];

        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_trial = div_shift - {1'b0, opb_q};
        div_ok    = ~div_trial[WIDTH];
        div_rem   = div_ok ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        div_quo   = {lo_q[WIDTH-2:0], div_ok};
        div_res   = mode_q[1] ? (rneg_q ? -div_rem : div_rem)
                              : (fix_q  ? -div_quo : div_quo);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        fix_d   = fix_q;
        rneg_d  = rneg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opb_d   = opb_q;
        res_d   = res_q;
        z_d     = z_q;
        n_d     = n_q;
        load    = 1'b0;
        res_nx  = res_q;
        a_s     = 1'b0;
        b_s     = 1'b0;
        sgn     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (op[4:2] == 3'b100) begin
                        a_s     = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
                        b_s     = (op[1:0] == 2'b01);
                        mode_d  = op[1:0];
                        hi_d    = '0;
                        lo_d    = abs_val(a_in, a_s);
                        opb_d   = abs_val(b_in, b_s);
                        fix_d   = (a_s & a_in[WIDTH-1]) ^ (b_s & b_in[WIDTH-1]);
                        cnt_d   = CNT_INIT;
                        state_d = MUL;
                    end else if (op[4:2] == 3'b101) begin
                        sgn    = ~op[0];
                        mode_d = op[1:0];
                        if (b_in == '0) begin
                            res_nx = op[1] ? a_in : '1;
                            load   = 1'b1;
                        end else if (sgn && a_in == MIN_VAL && b_in == '1) begin
                            res_nx = op[1] ? '0 : MIN_VAL;
                            load   = 1'b1;
                        end else begin
                            hi_d    = '0;
                            lo_d    = abs_val(a_in, sgn);
                            opb_d   = abs_val(b_in, sgn);
                            fix_d   = sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
                            rneg_d  = sgn & a_in[WIDTH-1];
                            cnt_d   = CNT_INIT;
                            state_d = DIV;
                        end
                    end else begin
                        res_nx = base_res;
                        load   = 1'b1;
                    end
                end
            end
            MUL: begin
                hi_d  = mul_prod[2*WIDTH-1:WIDTH];
                lo_d  = mul_prod[WIDTH-1:0];
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_nx = mul_res;
                    load   = 1'b1;
                end
            end
            DIV: begin
                hi_d  = div_rem;
                lo_d  = div_quo;
                cnt_d = cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE) begin
                    res_nx = div_res;
                    load   = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (load) state_d = DONE;

        // Flush wins over everything; the result registers keep their last value.
        if (kill) begin
            state_d = IDLE;
            load    = 1'b0;
        end

        if (load) begin
            res_d = res_nx;
            z_d   = (res_nx == '0);
            n_d   = res_nx[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= '0;
            fix_q   <= 1'b0;
            rneg_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            z_q     <= 1'b1;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            fix_q   <= fix_d;
            rneg_q  <= rneg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            z_q     <= z_d;
            n_q     <= n_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign ALUResult = res_q;
    assign Z         = z_q;
    assign NEG       = n_q;

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized and directed bench for alu_mdu (WIDTH=32) against an arithmetic reference model.

module tb_alu_mdu;

    logic        clk = 1'b0;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op;
    logic [31:0] a_in, b_in;
    logic        kill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ALUResult;
    logic        Z, NEG;

    int checks   = 0;
    int failures = 0;

    alu_mdu #(.WIDTH(32)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a_in(a_in), .b_in(b_in), .kill(kill), .out_valid(out_valid),
        .out_ready(out_ready), .ALUResult(ALUResult), .Z(Z), .NEG(NEG)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%h exp=0x%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, ps;
        logic [63:0]        up;
        logic signed [31:0] a32, b32;
        sa  = {{32{a[31]}}, a};
        sb  = {{32{b[31]}}, b};
        ub  = {32'b0, b};
        a32 = a;
        b32 = b;
        case (o)
            5'b00000: return a + b;
            5'b00001: return a - b;
            5'b00010: return a & b;
            5'b00011: return a ^ b;
            5'b00101: return (a32 < b32) ? 32'd1 : 32'd0;
            5'b00110: return a | b;
            5'b01000: return (a < b) ? 32'd1 : 32'd0;
            5'b01001: return a << b[4:0];
            5'b01010: return a >> b[4:0];
            5'b01011: return a32 >>> b[4:0];
            5'b10000: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            5'b10001: begin ps = sa * sb; return ps[63:32]; end
            5'b10010: begin ps = sa * ub; return ps[63:32]; end
            5'b10011: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            5'b10100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return a32 / b32;
            end
            5'b10101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            5'b10110: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return a32 % b32;
            end
            5'b10111: return (b == 0) ? a : a % b;
            default:  return 32'h5555_5555;
        endcase
    endfunction

    function automatic int ref_lat(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[4:2] == 3'b100) return 33;
        if (o[4:2] == 3'b101) begin
            if (b == 0) return 1;
            if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
            return 33;
        end
        return 1;
    endfunction

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_idle", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b, input int hold);
        logic [31:0] e;
        int          el, lat;
        logic        busy_bad;
        e  = ref_res(o, a, b);
        el = ref_lat(o, a, b);
        wait_idle();
        op = o; a_in = a; b_in = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom); a_in = $urandom; b_in = $urandom;
        lat = 1;
        busy_bad = 1'b0;
        while (!out_valid && lat < 100) begin
            if (in_ready) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        chk($sformatf("lat op=%b a=%h b=%h", o, a, b), lat, el);
        chk($sformatf("res op=%b a=%h b=%h", o, a, b), ALUResult, e);
        chk($sformatf("z op=%b", o), {31'b0, Z}, {31'b0, e == 0});
        chk($sformatf("neg op=%b", o), {31'b0, NEG}, {31'b0, e[31]});
        chk($sformatf("busy_rdy op=%b", o), {31'b0, busy_bad}, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            a_in = $urandom; b_in = $urandom; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("hold_res", ALUResult, e);
            chk("hold_vld", {31'b0, out_valid}, 32'd1);
            chk("hold_rdy", {31'b0, in_ready}, 32'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("back_idle", {31'b0, in_ready}, 32'd1);
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    logic [31:0] prev;
    logic        seen;

    initial begin
        resetn = 1'b0; in_valid = 1'b0; kill = 1'b0; out_ready = 1'b0;
        op = '0; a_in = '0; b_in = '0;
        #12;
        chk("rst_res", ALUResult, 32'h0);
        chk("rst_z", {31'b0, Z}, 32'd1);
        chk("rst_neg", {31'b0, NEG}, 32'd0);
        chk("rst_vld", {31'b0, out_valid}, 32'd0);
        chk("rst_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        resetn = 1'b1;

        run_op(5'b00000, 32'h7FFF_FFFF, 32'h1, 0);
        run_op(5'b00001, 32'd5, 32'd5, 0);
        run_op(5'b01000, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(5'b00101, 32'd1, 32'hFFFF_FFFF, 0);
        run_op(5'b01011, 32'h8000_0000, 32'h24, 0);
        run_op(5'b10000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(5'b10100, -32'sd7, 32'd2, 0);
        run_op(5'b10110, -32'sd7, 32'd2, 0);
        run_op(5'b10101, 32'd100, 32'd7, 0);
        run_op(5'b10111, 32'd100, 32'd7, 0);
        run_op(5'b10101, 32'd9, 32'd0, 0);
        run_op(5'b10111, 32'd9, 32'd0, 0);
        run_op(5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(5'b11111, 32'h1234_5678, 32'h9, 0);
        run_op(5'b00000, 32'd40, 32'd2, 5);

        // request held through the DONE->IDLE cycle is accepted one cycle later
        wait_idle();
        op = 5'b00011; a_in = 32'hF0; b_in = 32'h0F; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 5'b00000; a_in = 32'd2; b_in = 32'd3;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bubble_rdy", {31'b0, in_ready}, 32'd1);
        chk("bubble_vld", {31'b0, out_valid}, 32'd0);
        chk("bubble_res", ALUResult, 32'hFF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bubble_acc_vld", {31'b0, out_valid}, 32'd1);
        chk("bubble_acc_res", ALUResult, 32'd5);
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;

        // kill wins over accept in IDLE
        @(negedge clk);
        op = 5'b00000; a_in = 32'd7; b_in = 32'd7; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_acc_rdy", {31'b0, in_ready}, 32'd1);
        chk("kill_acc_vld", {31'b0, out_valid}, 32'd0);

        // kill at MUL cycle 10
        wait_idle();
        prev = ALUResult;
        op = 5'b10000; a_in = 32'd3; b_in = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1; kill = 1'b0;
        chk("kill_mul_rdy", {31'b0, in_ready}, 32'd1);
        chk("kill_mul_vld", {31'b0, out_valid}, 32'd0);
        chk("kill_mul_res", ALUResult, prev);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("kill_mul_never", {31'b0, seen}, 32'd0);

        // kill wins over out_ready in DONE
        wait_idle();
        op = 5'b00110; a_in = 32'h100; b_in = 32'h1; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        @(negedge clk); kill = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1; kill = 1'b0; out_ready = 1'b0;
        chk("kill_done_vld", {31'b0, out_valid}, 32'd0);
        chk("kill_done_res", ALUResult, 32'h101);

        // async reset mid-DIV
        wait_idle();
        op = 5'b10101; a_in = 32'd100; b_in = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk); resetn = 1'b0;
        #1;
        chk("rst_div_res", ALUResult, 32'h0);
        chk("rst_div_z", {31'b0, Z}, 32'd1);
        chk("rst_div_neg", {31'b0, NEG}, 32'd0);
        chk("rst_div_vld", {31'b0, out_valid}, 32'd0);
        chk("rst_div_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk); resetn = 1'b1;
        run_op(5'b00000, 32'd2, 32'd3, 0);

        for (int i = 0; i < 250; i++)
            run_op(5'($urandom_range(0, 31)), rnd_val(), rnd_val(), int'($urandom_range(0, 2)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle integer ALU.
- Adds the RV32M multiply/divide operations and the missing base ops (sltu, shifts).
- Result, zero and negative flags are registered behind a valid/ready handshake.
- Sits in the execute stage: base ops complete in 1 cycle; multiply/divide run iteratively, one bit per cycle, and stall the pipeline through in_ready.

Parameters:
- WIDTH, 32, operand/result width in bits (>=8, power of two).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  clock, rising edge.
- resetn  input  1  asynchronous reset, active low.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept a request this cycle.
- op  input  5  operation select (encoding below).
- a_in  input  WIDTH  operand A (rs1).
- b_in  input  WIDTH  operand B (rs2/imm).
- kill  input  1  synchronous abort (pipeline flush).
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  consumer takes the result.
- ALUResult  output  WIDTH  registered result.
- Z  output  1  ALUResult == 0.
- NEG  output  1  ALUResult[WIDTH-1].

Behaviour:
- Reset (resetn=0, async) puts the FSM in IDLE and sets in_ready=1, out_valid=0, ALUResult=0, Z=1, NEG=0. Internal accumulators and counter clear.
- Opcodes:
  - 00000 add, 00001 sub, 00010 and, 00011 xor, 00101 slt (signed), 00110 or.
  - 01000 sltu, 01001 sll, 01010 srl, 01011 sra.
  - 10000 mul, 10001 mulh, 10010 mulhsu, 10011 mulhu.
  - 10100 div, 10101 divu, 10110 rem, 10111 remu.
  - Any other code gives result {WIDTH/2{2'b01}} (0x55555555 at 32) with 1-cycle latency.
- Shifts use shamt = b_in[$clog2(WIDTH)-1:0]; upper bits are ignored.
- FSM states: IDLE, MUL, DIV, DONE.
  - in_ready = (state==IDLE). A request is accepted when in_valid && in_ready.
  - IDLE + accept, base/unknown op: compute combinationally, register into ALUResult/Z/NEG, go to DONE. out_valid is high the next cycle (latency 1).
  - IDLE + accept, mul*: latch operands (sign handling per op; magnitude + result-sign for mulh/mulhsu), counter=WIDTH, go to MUL.
  - MUL: one shift-add step per cycle, counter decrements. At counter==1, apply sign correction, select the low (mul) or high (mulh*) WIDTH bits of the 2*WIDTH product, register, go to DONE. Total latency WIDTH+1 cycles from accept to out_valid.
  - IDLE + accept, div*/rem*: three cases.
    - b_in==0: quotient all-ones, remainder=a_in, straight to DONE (latency 1).
    - Signed div/rem with a_in=MIN and b_in=-1: quotient=MIN, remainder=0, latency 1.
    - Otherwise: restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles in DIV. Then sign-fix: the quotient is negated if the operand signs differ; the remainder takes the sign of the dividend. Register and go to DONE. Latency WIDTH+1.
  - DONE: out_valid=1, and ALUResult/Z/NEG are held stable until out_ready. Going DONE to IDLE takes out_ready=1; no new request is accepted in that same cycle, giving a minimum 1-cycle bubble.
- Z and NEG are always derived from the value being registered into ALUResult, in the same clock edge. They are never combinational on the inputs.
- Operands are captured at accept. Changes on a_in/b_in/op while the unit is not in IDLE have no effect.
- kill=1 (synchronous) takes any state to IDLE with out_valid=0 on the next edge. ALUResult/Z/NEG keep their last value.
  - kill has priority over accept: with kill=1 in IDLE, no request is accepted.
  - kill has priority over out_ready.
- in_valid while busy is ignored; the requester must hold the request until in_ready.
- Asynchronous reset mid-MUL/DIV abandons the operation immediately. The first post-reset accept behaves as if from cold.

Test Plan:
- Base ops, WIDTH=32:
  - add 0x7FFFFFFF+1 -> 0x80000000, NEG=1, Z=0, out_valid 1 cycle after accept.
  - sub 5-5 -> 0, Z=1.
  - sltu 1,0xFFFFFFFF -> 1; slt 1,0xFFFFFFFF -> 0.
  - sra 0x80000000 by 0x24 (shamt 4) -> 0xF8000000.
- Multiply:
  - mul 0xFFFFFFFF*0xFFFFFFFF -> 1.
  - mulh -> 0; mulhu -> 0xFFFFFFFE; mulhsu(-1,0xFFFFFFFF) -> 0xFFFFFFFF.
  - Each has out_valid exactly 33 cycles after accept, with in_ready=0 throughout.
- Divide:
  - div -7/2 -> 0xFFFFFFFD; rem -7/2 -> 0xFFFFFFFF; divu 100/7 -> 14; remu -> 2. Each has latency 33.
- Corner divides:
  - divu 9/0 -> 0xFFFFFFFF; remu 9/0 -> 9.
  - div 0x80000000/-1 -> 0x80000000; rem -> 0, Z=1.
  - All have latency 1.
- Handshake and abort:
  - Hold out_ready=0 for 5 cycles in DONE: result stays stable, in_ready=0; accept occurs the cycle after out_ready drops to IDLE.
  - kill at MUL cycle 10 -> IDLE next edge, out_valid never rises.
  - resetn low mid-DIV -> outputs at reset values asynchronously, then a clean add 2+3=5.
- Unknown op 11111 -> 0x55555555, Z=0, NEG=0, latency 1.
